uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver; the counterpart of the Tx-side baud generator and transmitter.
- Generates its own 16x-oversampling strobe with a phase accumulator (same carry-out technique as the Tx baud generator), synchronises the serial input, and validates the start bit at mid-bit.
- Samples data LSB-first and checks the stop bit.
- Presents each byte on a valid/ready holding register to the downstream consumer.

Parameters:
- ACC_WIDTH, 32, phase accumulator width in bits.
- INCREMENT, 13743895, per-clock accumulator step. Default is round(2^32*16*9600/48e6): 16x oversampling of 9600 bps at 48 MHz.
- DATA_BITS, 8, data bits per frame (1..8).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronous to clk
- rx  input  1  serial line, idles high, asynchronous to clk
- rx_data  output  DATA_BITS  last accepted byte, LSB = first bit received
- rx_valid  output  1  rx_data holds an unconsumed byte
- rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready
- framing_err  output  1  one-cycle pulse: stop bit sampled low
- overrun_err  output  1  one-cycle pulse: frame completed while rx_valid still set

Behaviour:
- Reset values: acc=0, tick=0, sync flops=1, state=IDLE, os_cnt=0, bit_cnt=0, shift=0, rx_data=0, rx_valid=0, framing_err=0, overrun_err=0.
- Oversample strobe: {tick, acc} <= acc + INCREMENT on every clk. tick is a registered one-cycle pulse. All FSM sampling is qualified by tick.
- Input synchronisation: rx passes through 2 flops to give rx_s. The FSM sees only rx_s, which adds 2 cycles of latency.
- os_cnt is 4 bits and counts ticks within a bit. It wraps 15->0.
- IDLE: on tick with rx_s=0, go to START with os_cnt=0.
- START: on each tick, os_cnt+1. On the tick where os_cnt==7 (mid start bit):
  - rx_s=0: go to DATA with os_cnt=0, bit_cnt=0.
  - rx_s=1: treat as a glitch and return to IDLE with no error.
- DATA: on the tick where os_cnt==15 (mid-bit, 16 ticks after the previous sample), shift right with rx_s entering the MSB (shift <= {rx_s, shift[DATA_BITS-1:1]}) and bit_cnt+1. When bit_cnt reaches DATA_BITS-1 and is sampled, go to STOP with os_cnt=0.
- STOP: on the tick where os_cnt==15, sample the stop bit:
  - rx_s=1 and rx_valid=0: rx_data<=shift, rx_valid<=1 on the next clk edge. Go to IDLE.
  - rx_s=1 and rx_valid=1 (and rx_ready=0 that cycle): overrun_err pulses for 1 cycle. rx_data keeps the old byte and the new byte is dropped. Go to IDLE.
  - rx_s=0: framing_err pulses for 1 cycle. rx_data and rx_valid are unchanged. Go to WAIT_HIGH.
- WAIT_HIGH: on tick with rx_s=1, go to IDLE. This prevents a break condition (line held low) from re-triggering.
- Handshake:
  - rx_valid clears on the clk edge where rx_valid & rx_ready.
  - If a stop bit completes in the same cycle as a handshake, the new byte is loaded and rx_valid stays 1. No overrun is flagged.
- framing_err and overrun_err are never asserted together. They are independent of rx_ready.
- Reset mid-frame: all state returns to reset values immediately. The next frame is detected only after a falling edge seen from IDLE.
- Accumulator wrap is intentional; the fractional baud error is bounded by 1/2^ACC_WIDTH per clock.

Test Plan:
Bench parameters: ACC_WIDTH=4, INCREMENT=8, DATA_BITS=8, giving tick every 2 clk, 1 bit = 32 clk.
- Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with rx_ready=1 -> rx_valid pulses exactly 1 cycle with rx_data=0xA5. No error pulses.
- rx low for 8 clk then high (glitch shorter than half a bit) -> FSM returns to IDLE. No rx_valid, no errors.
- Send 0x3C with stop bit held low, then hold rx low 200 clk, then high, then send 0x81 -> framing_err pulses once. No rx_valid for 0x3C. 0x81 is received correctly, proving no retrigger during the low hold.
- rx_ready=0; send 0x11 then 0x22 -> rx_valid=1 with rx_data=0x11. overrun_err pulses once at the end of 0x22, and rx_data stays 0x11. Raising rx_ready clears rx_valid next cycle.
- Assert rst_n=0 during data bit 3 of 0x55 -> all outputs 0 immediately. After release, 0xF0 is received correctly.
- Back-to-back frames 0x00, 0xFF with zero idle gap, rx_ready=1 -> two rx_valid pulses with rx_data 0x00 then 0xFF.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a phase-accumulator 16x oversample strobe, a two-flop
// input synchroniser, mid-bit sampling and a valid/ready output holding register.
module uart_rx #(
    parameter int          ACC_WIDTH = 32,
    parameter longint unsigned INCREMENT = 13743895,
    parameter int          DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_err,
    output logic                 overrun_err
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);
    localparam logic [ACC_WIDTH:0] INC = (ACC_WIDTH + 1)'(INCREMENT);

    logic [ACC_WIDTH-1:0] acc_reg;
    logic                 tick_reg;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [1:0]           sync_reg;
    logic                 rx_s;

    logic [2:0]           state_reg, state_next;
    logic [3:0]           os_reg, os_next;
    logic [BCW-1:0]       bit_reg, bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 stop_sample;

    // The carry out of the accumulator is the oversample strobe.
    assign acc_sum = {1'b0, acc_reg} + INC;
    assign rx_s    = sync_reg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            tick_reg <= 1'b0;
            sync_reg <= 2'b11;
        end else begin
            {tick_reg, acc_reg} <= acc_sum;
            sync_reg <= {sync_reg[0], rx};
        end
    end

    always_comb begin
        state_next  = state_reg;
        os_next     = os_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        stop_sample = 1'b0;
        if (tick_reg) begin
            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                        os_next    = 4'd0;
                    end
                end
                START: begin
                    os_next = os_reg + 4'd1;
                    if (os_reg == 4'd7) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            os_next    = 4'd0;
                            bit_next   = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                DATA: begin
                    os_next = os_reg + 4'd1;
                    if (os_reg == 4'd15) begin
                        // LSB-first: each new bit enters at the top and moves down.
                        shift_next = (shift_reg >> 1) |
                                     (DATA_BITS'(rx_s) << (DATA_BITS - 1));
                        bit_next   = bit_reg + 1'b1;
                        if (bit_reg == LAST_BIT) begin
                            state_next = STOP;
                            os_next    = 4'd0;
                        end
                    end
                end
                STOP: begin
                    os_next = os_reg + 4'd1;
                    if (os_reg == 4'd15) begin
                        stop_sample = 1'b1;
                        state_next  = rx_s ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must return high before a new start.
                    if (rx_s) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            os_reg    <= 4'd0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            os_reg    <= os_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            framing_err <= stop_sample & ~rx_s;
            overrun_err <= stop_sample & rx_s & rx_valid & ~rx_ready;
            // A handshake in the completing cycle frees the register for the new byte.
            if (stop_sample && rx_s && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
